// File: rtl/digit_reg_pkg.sv
// Command encodings shared by the digit register and the calculator control FSM.
package digit_reg_pkg;

    localparam int CMD_W = 3;

    localparam logic [CMD_W-1:0] CMD_NOP   = 3'd0;
    localparam logic [CMD_W-1:0] CMD_LOAD  = 3'd1;
    localparam logic [CMD_W-1:0] CMD_PUSH  = 3'd2;
    localparam logic [CMD_W-1:0] CMD_POP   = 3'd3;
    localparam logic [CMD_W-1:0] CMD_CLEAR = 3'd4;
    localparam logic [CMD_W-1:0] CMD_ROTL  = 3'd5;
    localparam logic [CMD_W-1:0] CMD_ROTR  = 3'd6;
    localparam logic [CMD_W-1:0] CMD_RSVD  = 3'd7;

    // Width of a counter that can hold 0..ndig inclusive.
    function automatic int cntWidth(input int ndig);
        return $clog2(ndig + 1);
    endfunction

endpackage

// File: rtl/digit_shift_reg_if.sv
// Command/status bundle between the control FSM (master) and the digit register (slave).
interface digit_shift_reg_if
    import digit_reg_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DIGIT_W = 4
);
    localparam int NDIG  = DATA_W / DIGIT_W;
    localparam int CNT_W = cntWidth(NDIG);

    logic               cmd_valid;
    logic [CMD_W-1:0]   cmd;
    logic [DATA_W-1:0]  din;
    logic [DIGIT_W-1:0] digit_in;
    logic [DATA_W-1:0]  out;
    logic [DIGIT_W-1:0] pop_digit;
    logic [CNT_W-1:0]   cnt;
    logic               full;
    logic               empty;
    logic               done;
    logic               err;

    modport master (
        output cmd_valid, cmd, din, digit_in,
        input  out, pop_digit, cnt, full, empty, done, err
    );

    modport slave (
        input  cmd_valid, cmd, din, digit_in,
        output out, pop_digit, cnt, full, empty, done, err
    );

endinterface

// File: rtl/digit_count.sv
// Priority encoder: number of significant digits (1 + index of the top nonzero digit).
module digit_count
    import digit_reg_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DIGIT_W = 4,
    localparam int NDIG   = DATA_W / DIGIT_W,
    localparam int CNT_W  = cntWidth(NDIG)
) (
    input  logic [DATA_W-1:0] value_i,
    output logic [CNT_W-1:0]  cnt_o
);

    // Ascending scan so the most significant nonzero digit wins.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (value_i[i*DIGIT_W +: DIGIT_W] != '0) begin
                cnt_o = CNT_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/digit_shift_reg.sv
// Digit-oriented operand register: load, keypad push, backspace pop, clear and rotate.
module digit_shift_reg
    import digit_reg_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DIGIT_W = 4,
    localparam int NDIG   = DATA_W / DIGIT_W,
    localparam int CNT_W  = cntWidth(NDIG)
) (
    input  logic             clk,
    input  logic             rst,
    digit_shift_reg_if.slave bus
);

    logic [DATA_W-1:0]  data_q, data_d;
    logic [DIGIT_W-1:0] popDigit_q, popDigit_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   digitCnt;
    logic               isFull;
    logic               isEmpty;

    digit_count #(
        .DATA_W  (DATA_W),
        .DIGIT_W (DIGIT_W)
    ) u_count (
        .value_i (data_q),
        .cnt_o   (digitCnt)
    );

    assign isFull  = (digitCnt == CNT_W'(NDIG));
    assign isEmpty = (digitCnt == '0);

    always_comb begin
        data_d     = data_q;
        popDigit_d = popDigit_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (bus.cmd_valid) begin
            case (bus.cmd)
                CMD_NOP: begin
                end
                CMD_LOAD: begin
                    data_d = bus.din;
                    done_d = 1'b1;
                end
                CMD_PUSH: begin
                    // A leading zero pushed into an empty register simply leaves it at zero.
                    if (isFull) begin
                        err_d = 1'b1;
                    end else begin
                        data_d = {data_q[DATA_W-DIGIT_W-1:0], bus.digit_in};
                        done_d = 1'b1;
                    end
                end
                CMD_POP: begin
                    if (isEmpty) begin
                        err_d = 1'b1;
                    end else begin
                        popDigit_d = data_q[DIGIT_W-1:0];
                        data_d     = {{DIGIT_W{1'b0}}, data_q[DATA_W-1:DIGIT_W]};
                        done_d     = 1'b1;
                    end
                end
                CMD_CLEAR: begin
                    data_d = '0;
                    done_d = 1'b1;
                end
                CMD_ROTL: begin
                    data_d = {data_q[DATA_W-DIGIT_W-1:0], data_q[DATA_W-1:DATA_W-DIGIT_W]};
                    done_d = 1'b1;
                end
                CMD_ROTR: begin
                    data_d = {data_q[DIGIT_W-1:0], data_q[DATA_W-1:DIGIT_W]};
                    done_d = 1'b1;
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end
    end

    // Reset wins over any command issued in the same cycle; no pulse is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            popDigit_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            data_q     <= data_d;
            popDigit_q <= popDigit_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.out       = data_q;
    assign bus.pop_digit = popDigit_q;
    assign bus.cnt       = digitCnt;
    assign bus.full      = isFull;
    assign bus.empty     = isEmpty;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: doc/digit_shift_reg.md
Name: digit_shift_reg

Overview:
- Parametrised successor of the calculator's nibble data register.
- Holds a DATA_W-bit operand as NDIG = DATA_W/DIGIT_W digits.
- Operations: load, push digit (keypad entry), pop digit (backspace, display readout), clear, rotate left/right.
- Tracks the significant-digit count and flags rejected operations.
- Sits between the keypad/ALU datapath and the control FSM. Control issues one command per cycle with a valid strobe, replacing raw FSM state decoding.

Parameters:
- DATA_W, 16, register width in bits; must be a multiple of DIGIT_W.
- DIGIT_W, 4, digit width in bits (4 = hex).
- NDIG, DATA_W/DIGIT_W, derived localparam, number of digits; not overridable.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command strobe; cmd is ignored when low.
- cmd  in  3  command code (encodings in package).
- din  in  DATA_W  parallel load value (LOAD).
- digit_in  in  DIGIT_W  digit pushed (PUSH).
- out  out  DATA_W  register contents.
- pop_digit  out  DIGIT_W  last digit removed by POP.
- cnt  out  clog2(NDIG+1)  significant digits in out.
- full  out  1  cnt == NDIG.
- empty  out  1  cnt == 0 (out == 0).
- done  out  1  one-cycle pulse, accepted command completed.
- err  out  1  one-cycle pulse, command rejected.

Behaviour:
- Reset: out=0, pop_digit=0, done=0, err=0, giving cnt=0, empty=1, full=0.
- Reset has priority over any command in the same cycle.
- Commands: NOP=0, LOAD=1, PUSH=2, POP=3, CLEAR=4, ROTL=5, ROTR=6; code 7 is reserved.
- Commands are sampled on the edge where cmd_valid=1. The result is visible on out the same edge (latency 1). done or err is asserted for exactly the following cycle.
- At most one of done/err is high in any cycle. Both are low after a NOP or cmd_valid=0.
- LOAD: out<=din; done.
- PUSH:
  - If full: out unchanged, err.
  - Else: out <= {out[DATA_W-DIGIT_W-1:0], digit_in}; done.
  - Pushing 0 while empty leaves out=0 and cnt=0 (no leading zeros). This is not an error; done.
- POP:
  - If empty: out and pop_digit unchanged, err.
  - Else: pop_digit <= out[DIGIT_W-1:0]; out <= {DIGIT_W zeros, out[DATA_W-1:DIGIT_W]}; done.
- CLEAR: out<=0; pop_digit unchanged; done (even if already empty).
- ROTL: out <= {out[DATA_W-DIGIT_W-1:0], out[DATA_W-1:DATA_W-DIGIT_W]}; done. Allowed when empty (result stays 0).
- ROTR: out <= {out[DIGIT_W-1:0], out[DATA_W-1:DIGIT_W]}; done.
- Reserved code 7: out unchanged, err.
- cnt is derived combinationally from registered out only; never from inputs. cnt = 1 + index of the most significant nonzero digit, or 0 if out==0.
  - cnt may jump after LOAD/ROTL/ROTR (e.g. 0x0001 ROTR -> 0x1000, cnt 1->4).
- full and empty are derived from cnt.
- Widths: no arithmetic on data; cnt saturates naturally at NDIG.
- Reset mid-sequence: clears out/pop_digit immediately; the pending command is discarded with no done/err.

Decomposition:
- Package digit_reg_pkg:
  - cmd code localparams (CMD_NOP..CMD_ROTR) and the CMD_W=3 constant;
  - shared with the control FSM.
- Sub-module digit_count: parametrised priority encoder, out -> cnt. Reused by display blanking logic.
- Everything else lives in digit_shift_reg.

Test Plan (DATA_W=16, DIGIT_W=4):
- Entry and backspace:
  - rst, then PUSH 1, 2, 3 -> out=0x0123, cnt=3, done pulse after each push.
  - Then PUSH 4 -> out=0x1234, full=1.
  - Then PUSH 5 -> err pulse, out stays 0x1234.
  - Then POP from 0x1234 -> out=0x0123, pop_digit=4, cnt=3.
  - Three more POPs -> out=0, empty=1, pop_digit=1.
  - Then POP -> err, pop_digit stays 1.
- Leading zero and load:
  - From reset, PUSH 0 -> out=0, cnt=0, done (no err).
  - LOAD 0x00A0 -> cnt=2.
  - LOAD 0xF000 -> full=1.
- Rotation:
  - LOAD 0x1234, then ROTL -> 0x2341.
  - ROTR twice -> 0x4123.
  - LOAD 0x0001, ROTR -> 0x1000, cnt=4.
- Command handling:
  - cmd=PUSH with cmd_valid=0 -> no change, no pulses.
  - cmd=7 with cmd_valid=1 -> err, out unchanged.
  - CLEAR on 0xBEEF -> out=0, done.
- Reset priority:
  - out=0x1234, assert rst together with cmd_valid=1, cmd=PUSH -> next cycle out=0, pop_digit=0, done=0, err=0.
